// File: rtl/full_st0_mem_ctrl_if.sv
// Stream-in, stream-out and data-memory bus bundle for the stage-0 memory controller.
// slave = controller view, master = environment view.
interface full_st0_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  in_valid, in_data, out_ready, mem_rd_data,
    output in_ready, out_valid, out_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
  );

  modport master (
    output in_valid, in_data, out_ready, mem_rd_data,
    input  in_ready, out_valid, out_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/full_st0_mem_ctrl.sv
// Stage-0 data memory initiator: streams words into memory and reads them back in order
// through a 2-entry buffer. Define FULL_ST0_MEM_CTRL_LEVEL_EN to add the registered level port.
module full_st0_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  full_st0_mem_ctrl_if.slave  bus,
  output logic                full,
  output logic                empty
`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
  ,
  output logic [ADDR_W:0]     level
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   mem_count, mem_count_nxt;
  logic              rd_pending;
  logic [1:0]        buf_cnt, buf_cnt_nxt;
  logic [DATA_W-1:0] buf0, buf1;
  logic              wr_fire, rd_fire, pop, push;
  logic [2:0]        buf_proj;

  assign bus.in_ready    = !reset && (mem_count != DEPTH_C);
  assign wr_fire         = bus.in_valid && bus.in_ready;
  assign bus.mem_wr_en   = wr_fire;
  assign bus.mem_wr_addr = wr_ptr;
  assign bus.mem_wr_data = bus.in_data;

  assign bus.out_valid = (buf_cnt != 2'd0);
  assign bus.out_data  = buf0;
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = rd_pending;

  // Buffer slots still claimed after this cycle; a new read is only issued into a free slot.
  assign buf_proj      = {1'b0, buf_cnt} + {2'b00, rd_pending} - {2'b00, pop};
  assign rd_fire       = !reset && (mem_count != '0) && (buf_proj < 3'd2);
  assign bus.mem_rd_en   = rd_fire;
  assign bus.mem_rd_addr = rd_ptr;

  assign full  = (mem_count == DEPTH_C);
  assign empty = (mem_count == '0) && !rd_pending && (buf_cnt == 2'd0);

  always_comb begin
    mem_count_nxt = mem_count;
    case ({wr_fire, rd_fire})
      2'b10:   mem_count_nxt = mem_count + 1'b1;
      2'b01:   mem_count_nxt = mem_count - 1'b1;
      default: mem_count_nxt = mem_count;
    endcase
    buf_cnt_nxt = buf_cnt;
    case ({push, pop})
      2'b10:   buf_cnt_nxt = buf_cnt + 1'b1;
      2'b01:   buf_cnt_nxt = buf_cnt - 1'b1;
      default: buf_cnt_nxt = buf_cnt;
    endcase
  end

  // Control state: pointers, counts, read-return flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
      buf_cnt    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      mem_count  <= mem_count_nxt;
      rd_pending <= rd_fire;
      buf_cnt    <= buf_cnt_nxt;
    end
  end

  // Read return: memory data lands in the output buffer one cycle after the read strobe.
  always_ff @(posedge clk) begin
    case ({push, pop})
      2'b10: begin
        if (buf_cnt == 2'd0) buf0 <= bus.mem_rd_data;
        else                 buf1 <= bus.mem_rd_data;
      end
      2'b01: buf0 <= buf1;
      2'b11: begin
        if (buf_cnt == 2'd2) begin
          buf0 <= buf1;
          buf1 <= bus.mem_rd_data;
        end else begin
          buf0 <= bus.mem_rd_data;
        end
      end
      default: ;
    endcase
  end

`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
  always_ff @(posedge clk) begin
    if (reset) level <= '0;
    else       level <= mem_count_nxt + (ADDR_W + 1)'(rd_fire) + (ADDR_W + 1)'(buf_cnt_nxt);
  end
`endif
endmodule

// File: tb/tb_full_st0_mem_ctrl.sv
// Self-checking bench for full_st0_mem_ctrl: queue-based occupancy/order model plus directed
// literal checks. Build with FULL_ST0_MEM_CTRL_LEVEL_EN to also exercise the level port.
module tb_full_st0_mem_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic reset;
  logic full, empty;
`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
  logic [ADDR_W:0] level;
`endif

  full_st0_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  full_st0_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .full  (full),
    .empty (empty)
`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
    ,
    .level (level)
`endif
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word sits in q until it is popped, so q.size() is the occupancy.
  logic [DATA_W-1:0] q[$];
  int                wr_cnt = 0;
  int                rd_cnt = 0;
  int                pops   = 0;
  logic              stall  = 1'b0;
  logic [DATA_W-1:0] stall_data;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_wr_en", bus.mem_wr_en, 1'b0);
      chk("rst_rd_en", bus.mem_rd_en, 1'b0);
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
      stall  = 1'b0;
    end else begin
      chk("in_ready_vs_full", bus.in_ready, !full);
      if (full) chk("full_occupancy", q.size() >= DEPTH, 1'b1);
      chk("occupancy_max", q.size() <= DEPTH + 2, 1'b1);
      chk("empty", empty, q.size() == 0);
`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
      chk("level", level, q.size());
`endif
      chk("wr_en", bus.mem_wr_en, bus.in_valid && bus.in_ready);
      if (bus.mem_wr_en) begin
        chk("wr_addr", bus.mem_wr_addr, wr_cnt % DEPTH);
        chk("wr_data", bus.mem_wr_data, bus.in_data);
      end
      if (bus.mem_rd_en) begin
        chk("rd_addr", bus.mem_rd_addr, rd_cnt % DEPTH);
        chk("rd_readable", rd_cnt < wr_cnt, 1'b1);
      end
      if (stall) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_data", bus.out_data, stall_data);
      end
      if (bus.out_valid) begin
        if (q.size() == 0) chk("out_unexpected", bus.out_valid, 1'b0);
        else               chk("out_data", bus.out_data, q[0]);
      end
      if (bus.mem_wr_en) begin
        q.push_back(bus.in_data);
        wr_cnt++;
      end
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        pops++;
      end
      stall      = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      tick();
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("send_timeout", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int k;
    k = 0;
    while (!empty && k < bound) begin
      tick();
      k++;
    end
    chk("drain_timeout", empty, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, sent, cyc, k;
    logic acc;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    tick();

    // Single word latency: write cycle 0, read cycle 1, output cycle 3
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_wr_en_c0", bus.mem_wr_en, 1'b1);
    chk("t1_wr_addr_c0", bus.mem_wr_addr, 6'd0);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_rd_en_c1", bus.mem_rd_en, 1'b1);
    chk("t1_rd_addr_c1", bus.mem_rd_addr, 6'd0);
    chk("t1_out_valid_c1", bus.out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_out_valid_c2", bus.out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_out_valid_c3", bus.out_valid, 1'b1);
    chk("t1_out_data_c3", bus.out_data, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t1_empty_c4", empty, 1'b1);
    chk("t1_out_valid_c4", bus.out_valid, 1'b0);
    tick();

    // Fill to capacity with the output stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 66; i++) send(32'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd66;
    @(negedge clk);
    chk("t2_in_ready_full", bus.in_ready, 1'b0);
    chk("t2_full", full, 1'b1);
`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
    chk("t2_level_66", level, 7'd66);
`endif
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_first_out", bus.out_data, 32'd0);
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t2_full_after_pop", full, 1'b0);
`ifdef FULL_ST0_MEM_CTRL_LEVEL_EN
    chk("t2_level_65", level, 7'd65);
`endif
    tick();
    bus.out_ready = 1'b1;
    p0 = pops;
    wait_empty(300);
    chk("t2_drain_count", pops - p0, 65);

    // Continuous streaming: one word per cycle once the 3-cycle pipe is full
    p0 = pops;
    for (int i = 0; i < 200; i++) send(32'h1000 + 32'(i));
    chk("t3_stream_rate", pops - p0, 197);
    wait_empty(50);
    chk("t3_total_out", pops - p0, 200);

    // Random valid/ready
    sent = 0;
    cyc  = 0;
    bus.in_data = $urandom;
    while (sent < 1000 && cyc < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      tick();
      if (acc) bus.in_data = $urandom;
      cyc++;
    end
    chk("t4_words_sent", sent, 1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_empty(300);

    // Reset with words stored and a read in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h500 + 32'(i));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_pop_valid", bus.out_valid, 1'b1);
    chk("t5_read_issued", bus.mem_rd_en, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_out_valid_after_reset", bus.out_valid, 1'b0);
    chk("t5_empty_after_reset", empty, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    send(32'h1);
    k = 0;
    while (!bus.out_valid && k < 10) begin
      tick();
      k++;
    end
    chk("t5_first_valid", bus.out_valid, 1'b1);
    chk("t5_first_data", bus.out_data, 32'h1);
    wait_empty(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
